// File: rtl/serial_word_sequencer.sv
// Parallel-side driver/collector for a bit-serial two's-complement converter:
// shifts a latched word out LSB-first and gathers the returned bit stream.
// Optional result self-check is enabled by defining SEQ_SELF_CHECK_EN.
module serial_word_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_word,
    output logic             busy,
    output logic             conv_rst,
    output logic             ser_out,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             mismatch
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tx_sr_q;
    logic [WIDTH-1:0] rx_sr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             conv_rst_q;
    logic             ser_out_q;
    logic [WIDTH-1:0] out_word_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] rx_sr_d;
    logic             last_bit_d;
    logic             accept_d;

    assign rx_sr_d    = {ser_in, rx_sr_q[WIDTH-1:1]};
    assign last_bit_d = (cnt_q == CW'(WIDTH - 1));
    assign accept_d   = (state_q == IDLE) && start;

    // ser_out is registered one step ahead: the bit for the next SHIFT cycle
    // is loaded on the edge that enters that cycle, so tx_sr always holds
    // the bits still to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            conv_rst_q  <= 1'b1;
            ser_out_q   <= 1'b0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        tx_sr_q <= in_word;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q    <= SHIFT;
                    conv_rst_q <= 1'b0;
                    ser_out_q  <= tx_sr_q[0];
                    tx_sr_q    <= tx_sr_q >> 1;
                end
                SHIFT: begin
                    rx_sr_q <= rx_sr_d;
                    if (last_bit_d) begin
                        state_q     <= DONE;
                        conv_rst_q  <= 1'b1;
                        ser_out_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_word_q  <= rx_sr_d;
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        ser_out_q <= tx_sr_q[0];
                        tx_sr_q   <= tx_sr_q >> 1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_SELF_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             mismatch_q;

    // The expected negation is captured alongside the operand and compared
    // against the completed word on the same edge that publishes out_word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (accept_d) begin
            exp_q      <= (~in_word) + WIDTH'(1);
            mismatch_q <= 1'b0;
        end else if (state_q == SHIFT && last_bit_d) begin
            mismatch_q <= (rx_sr_d != exp_q);
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign busy      = busy_q;
    assign conv_rst  = conv_rst_q;
    assign ser_out   = ser_out_q;
    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_word_sequencer.sv
// Bench for serial_word_sequencer at WIDTH 8/16/32, each instance paired with a
// behavioural model of the bit-serial two's-complement converter.
module tb_serial_word_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  startV;
    logic [31:0] inW [3];
    logic [2:0]  busyV, convRstV, serOutV, serInV, outValidV, mismatchV;
    logic [2:0]  seenV;
    logic [2:0]  forceZeroV;
    logic [7:0]  ow8;
    logic [15:0] ow16;
    logic [31:0] ow32;

    int tests;
    int fails;

    serial_word_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(startV[0]), .in_word(inW[0][7:0]),
        .busy(busyV[0]), .conv_rst(convRstV[0]), .ser_out(serOutV[0]),
        .ser_in(serInV[0]), .out_word(ow8), .out_valid(outValidV[0]),
        .mismatch(mismatchV[0])
    );

    serial_word_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(startV[1]), .in_word(inW[1][15:0]),
        .busy(busyV[1]), .conv_rst(convRstV[1]), .ser_out(serOutV[1]),
        .ser_in(serInV[1]), .out_word(ow16), .out_valid(outValidV[1]),
        .mismatch(mismatchV[1])
    );

    serial_word_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(startV[2]), .in_word(inW[2]),
        .busy(busyV[2]), .conv_rst(convRstV[2]), .ser_out(serOutV[2]),
        .ser_in(serInV[2]), .out_word(ow32), .out_valid(outValidV[2]),
        .mismatch(mismatchV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter model: pass bits through until the first 1 has been seen,
    // invert every bit after it. forceZeroV breaks the link to provoke errors.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            seenV[i] <= convRstV[i] ? 1'b0 : (seenV[i] | serOutV[i]);
    end
    assign serInV = (serOutV ^ seenV) & ~forceZeroV;

    function automatic int wOf(input int s);
        return (s == 0) ? 8 : (s == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] maskOf(input int s);
        return (wOf(s) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wOf(s)) - 32'd1);
    endfunction

    function automatic logic [31:0] outWordOf(input int s);
        case (s)
            0:       return {24'b0, ow8};
            1:       return {16'b0, ow16};
            default: return ow32;
        endcase
    endfunction

    function automatic logic [31:0] negOf(input int s, input logic [31:0] x);
        return (32'd0 - x) & maskOf(s);
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        startV     = '0;
        forceZeroV = '0;
        for (int i = 0; i < 3; i++) inW[i] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if ({busyV[s], convRstV[s], serOutV[s], outValidV[s], mismatchV[s]} !== 5'b01000
                || outWordOf(s) !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reset w=%0d busy/convRst/ser/valid/mis got %b%b%b%b%b word %h want 01000 word 0",
                         wOf(s), busyV[s], convRstV[s], serOutV[s], outValidV[s], mismatchV[s], outWordOf(s));
            end
        end
        rst = 1'b0;
    endtask

    // One full conversion, checked cycle by cycle against the timing rules:
    // CLEAR after accept, WIDTH SHIFT cycles, then DONE with out_valid.
    task automatic convert(input int s, input logic [31:0] x, input bit noise, input string name);
        int          w;
        logic [31:0] xm;
        logic [31:0] expWord;
        logic        expMis;
        logic        expBusy, expValid, expConv, expSer;
        w       = wOf(s);
        xm      = x & maskOf(s);
        expWord = forceZeroV[s] ? 32'd0 : negOf(s, xm);
`ifdef SEQ_SELF_CHECK_EN
        expMis  = (expWord != negOf(s, xm));
`else
        expMis  = 1'b0;
`endif
        @(negedge clk);
        startV[s] = 1'b1;
        inW[s]    = xm;
        @(negedge clk);
        startV[s] = 1'b0;
        for (int k = 0; k <= w + 2; k++) begin
            if (k > 0) @(negedge clk);
            expBusy  = (k <= w + 1);
            expValid = (k == w + 1);
            expConv  = !(k >= 1 && k <= w);
            expSer   = (k >= 1 && k <= w) ? xm[k-1] : 1'b0;
            tests++;
            if ({busyV[s], outValidV[s], convRstV[s], serOutV[s]} !== {expBusy, expValid, expConv, expSer}) begin
                fails++;
                $display("[TB] FAIL %s w=%0d k=%0d busy/valid/convRst/ser got %b%b%b%b want %b%b%b%b",
                         name, w, k, busyV[s], outValidV[s], convRstV[s], serOutV[s],
                         expBusy, expValid, expConv, expSer);
            end
            if (k >= w + 1) begin
                tests++;
                if (outWordOf(s) !== expWord || mismatchV[s] !== expMis) begin
                    fails++;
                    $display("[TB] FAIL %s_result w=%0d k=%0d in %h got word %h mis %b want word %h mis %b",
                             name, w, k, xm, outWordOf(s), mismatchV[s], expWord, expMis);
                end
            end
            if (noise && k <= w + 1) begin
                startV[s] = 1'($urandom);
                inW[s]    = $urandom;
            end
        end
        startV[s] = 1'b0;
    endtask

    task automatic test_directed();
        convert(0, 32'h93, 0, "dir93");
        convert(0, 32'h00, 0, "dir00");
        convert(0, 32'hFF, 0, "dirFF");
        convert(0, 32'h30, 0, "dir30");
        convert(1, 32'h6666, 0, "dir6666");
        convert(1, 32'h7EEE, 0, "dir7EEE");
        convert(2, 32'h00EE0080, 0, "dir00EE0080");
    endtask

    task automatic test_ignore_start();
        for (int i = 0; i < 3; i++) convert(i, $urandom, 1, "ignore");
    endtask

    task automatic test_back_to_back();
        int          w;
        logic [31:0] a, b;
        logic        expBusy, expValid;
        logic [31:0] expWord;
        w = 32;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        startV[2] = 1'b1;
        inW[2]    = a;
        for (int k = 0; k <= 2 * w + 5; k++) begin
            @(negedge clk);
            if (k == 1) inW[2] = b;
            expBusy  = !(k == w + 2 || k == 2 * w + 5);
            expValid = (k == w + 1 || k == 2 * w + 4);
            tests++;
            if ({busyV[2], outValidV[2]} !== {expBusy, expValid}) begin
                fails++;
                $display("[TB] FAIL b2b k=%0d busy/valid got %b%b want %b%b",
                         k, busyV[2], outValidV[2], expBusy, expValid);
            end
            if (expValid) begin
                expWord = (k == w + 1) ? negOf(2, a) : negOf(2, b);
                tests++;
                if (ow32 !== expWord) begin
                    fails++;
                    $display("[TB] FAIL b2b_word k=%0d got %h want %h", k, ow32, expWord);
                end
            end
        end
        startV[2] = 1'b0;
    endtask

    task automatic test_rst_mid_shift();
        int validSeen;
        convert(0, 32'h01, 0, "preRst");
        @(negedge clk);
        startV[0] = 1'b1;
        inW[0]    = 32'h5A;
        @(negedge clk);
        startV[0] = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (serOutV[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_pre bit3 ser got %b want 1", serOutV[0]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busyV[0], convRstV[0], serOutV[0], outValidV[0]} !== 4'b0100 || ow8 !== 8'h00) begin
            fails++;
            $display("[TB] FAIL rst_mid busy/convRst/ser/valid got %b%b%b%b word %h want 0100 word 00",
                     busyV[0], convRstV[0], serOutV[0], outValidV[0], ow8);
        end
        @(negedge clk);
        rst = 1'b0;
        validSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (outValidV[0] || busyV[0] || !convRstV[0]) validSeen++;
        end
        tests++;
        if (validSeen != 0) begin
            fails++;
            $display("[TB] FAIL rst_after activity cycles got %0d want 0", validSeen);
        end
        convert(0, 32'hA7, 0, "postRst");
    endtask

    task automatic test_mismatch();
        forceZeroV[0] = 1'b1;
        convert(0, 32'h93, 0, "mismatch");
        forceZeroV[0] = 1'b0;
        convert(0, 32'h93, 0, "mismatchClear");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) convert($urandom_range(0, 2), $urandom, 0, "random");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_rst_mid_shift();
        test_mismatch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
